// File: rtl/div_mon_pkg.sv
// Shared types and defaults for the divided-clock monitor.
// Combinational only; no backpressure.
`timescale 1ns/1ps
package div_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SYNC    = 2'd1,
        ST_MEASURE = 2'd2,
        ST_LOCKED  = 2'd3
    } mon_state_t;

    localparam int DEF_CW       = 8;
    localparam int DEF_EW       = 4;
    localparam int DEF_LOCK_CNT = 4;

    function automatic int cnt_max_of(input int cw);
        return (1 << cw) - 1;
    endfunction

    localparam int CNT_MAX = cnt_max_of(DEF_CW);

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer plus edge register; rise/fall are single-cycle pulses.
// Latency: edge reported 2-3 core cycles after the pin toggles; no backpressure.
`timescale 1ns/1ps
module sync_edge_detect (
    input  logic i_clk,
    input  logic i_clear_n,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic r_s1;
    logic r_s2;
    logic r_s3;

    always_ff @(posedge i_clk or negedge i_clear_n) begin
        if (!i_clear_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= i_async;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign o_level = r_s2;
    assign o_rise  = r_s2 & ~r_s3;
    assign o_fall  = ~r_s2 & r_s3;

endmodule

// File: rtl/div_clk_monitor.sv
// Measures period/high time of an asynchronous divided clock and checks it against expected_div.
// Latency: results and pulses one cycle after the synchronized rising edge; no backpressure.
`timescale 1ns/1ps
module div_clk_monitor
    import div_mon_pkg::*;
#(
    parameter int CW       = DEF_CW,
    parameter int EW       = DEF_EW,
    parameter int LOCK_CNT = DEF_LOCK_CNT
) (
    input  logic          clk,
    input  logic          clear_n,
    input  logic          enable,
    input  logic          div_clk_in,
    input  logic [CW-1:0] expected_div,
    input  logic [CW-1:0] tolerance,
    output logic [CW-1:0] period,
    output logic [CW-1:0] high_time,
    output logic          period_valid,
    output logic          locked,
    output logic          mismatch,
    output logic          timeout,
    output logic [EW-1:0] err_count
);

    localparam int              MRW     = $clog2(LOCK_CNT + 1);
    localparam logic [CW-1:0]   CMAX    = CW'(cnt_max_of(CW));
    localparam logic [CW-1:0]   C_ONE   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [EW-1:0]   ERR_MAX = {EW{1'b1}};
    localparam logic [MRW-1:0]  RUN_TGT = MRW'(LOCK_CNT);

    mon_state_t     r_state;
    logic [CW-1:0]  r_cnt;
    logic [CW-1:0]  r_hcnt;
    logic [CW-1:0]  r_h_hold;
    logic [CW-1:0]  r_period;
    logic [CW-1:0]  r_high_time;
    logic           r_period_valid;
    logic           r_locked;
    logic           r_mismatch;
    logic           r_timeout;
    logic [EW-1:0]  r_err_count;
    logic [MRW-1:0] r_match_run;

    logic           w_level;
    logic           w_rise;
    logic           w_fall;
    logic [CW:0]    w_diff;
    logic           w_in_tol;
    logic           w_measuring;
    logic           w_mis_evt;
    logic           w_to_evt;
    logic [MRW-1:0] w_run_next;

    sync_edge_detect u_sync (
        .i_clk     (clk),
        .i_clear_n (clear_n),
        .i_async   (div_clk_in),
        .o_level   (w_level),
        .o_rise    (w_rise),
        .o_fall    (w_fall)
    );

    // Absolute deviation at CW+1 bits so large mismatches never wrap into tolerance.
    always_comb begin
        w_diff = '0;
        if (r_cnt >= expected_div)
            w_diff = {1'b0, r_cnt} - {1'b0, expected_div};
        else
            w_diff = {1'b0, expected_div} - {1'b0, r_cnt};
    end

    assign w_in_tol    = (w_diff <= {1'b0, tolerance});
    assign w_measuring = enable && ((r_state == ST_MEASURE) || (r_state == ST_LOCKED));
    assign w_mis_evt   = w_measuring && w_rise && !w_in_tol;
    assign w_to_evt    = w_measuring && !w_rise && (r_cnt == CMAX);
    assign w_run_next  = r_match_run + 1'b1;

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            r_state        <= ST_IDLE;
            r_cnt          <= '0;
            r_hcnt         <= '0;
            r_h_hold       <= '0;
            r_period       <= '0;
            r_high_time    <= '0;
            r_period_valid <= 1'b0;
            r_locked       <= 1'b0;
            r_mismatch     <= 1'b0;
            r_timeout      <= 1'b0;
            r_match_run    <= '0;
        end else begin
            r_period_valid <= 1'b0;
            r_mismatch     <= 1'b0;
            r_timeout      <= 1'b0;
            if (!enable) begin
                r_state     <= ST_IDLE;
                r_locked    <= 1'b0;
                r_match_run <= '0;
                r_cnt       <= '0;
                r_hcnt      <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: r_state <= ST_SYNC;
                    ST_SYNC: begin
                        // The partial period before the first rise is discarded.
                        if (w_rise) begin
                            r_cnt   <= C_ONE;
                            r_hcnt  <= C_ONE;
                            r_state <= ST_MEASURE;
                        end
                    end
                    default: begin
                        if (w_rise) begin
                            r_cnt          <= C_ONE;
                            r_hcnt         <= C_ONE;
                            r_period       <= r_cnt;
                            r_high_time    <= r_h_hold;
                            r_period_valid <= 1'b1;
                            if (!w_in_tol) begin
                                r_mismatch  <= 1'b1;
                                r_locked    <= 1'b0;
                                r_match_run <= '0;
                                r_state     <= ST_MEASURE;
                            end else if (r_state == ST_MEASURE) begin
                                r_match_run <= w_run_next;
                                if (w_run_next == RUN_TGT) begin
                                    r_locked <= 1'b1;
                                    r_state  <= ST_LOCKED;
                                end
                            end
                        end else if (w_to_evt) begin
                            r_timeout   <= 1'b1;
                            r_locked    <= 1'b0;
                            r_match_run <= '0;
                            r_cnt       <= '0;
                            r_hcnt      <= '0;
                            r_state     <= ST_SYNC;
                        end else begin
                            r_cnt <= r_cnt + C_ONE;
                            if (w_level && (r_hcnt != CMAX))
                                r_hcnt <= r_hcnt + C_ONE;
                            if (w_fall)
                                r_h_hold <= r_hcnt;
                        end
                    end
                endcase
            end
        end
    end

    // Survives enable; only clear_n wipes the error history.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n)
            r_err_count <= '0;
        else if ((w_mis_evt || w_to_evt) && (r_err_count != ERR_MAX))
            r_err_count <= r_err_count + 1'b1;
    end

    assign period       = r_period;
    assign high_time    = r_high_time;
    assign period_valid = r_period_valid;
    assign locked       = r_locked;
    assign mismatch     = r_mismatch;
    assign timeout      = r_timeout;
    assign err_count    = r_err_count;

endmodule

// File: doc/div_clk_monitor.md
Name: div_clk_monitor

Overview:
- Receive-side companion to the team's flip-flop-based clock frequency dividers: measures a divided clock against the system clock and checks the division ratio.
- Samples the asynchronous divided clock, measures its period and high time in clk cycles, and compares the period with an expected divisor.
- Reports lock, mismatch and timeout status.
- Sits beside each divider instance as a built-in self-check and status source for software or a top-level test harness.

Parameters:
- CW, 8, width of the period/high-time counters; maximum measurable period is 2^CW-1 cycles.
- EW, 4, width of the saturating error counter.
- LOCK_CNT, 4, number of consecutive in-tolerance periods required to assert locked (1..15).

Ports:
- clk  in  1  system/reference clock; the only clock in the block.
- clear_n  in  1  asynchronous active-low reset.
- enable  in  1  measurement enable; 0 forces IDLE.
- div_clk_in  in  1  divided clock under test; asynchronous to clk.
- expected_div  in  CW  expected period in clk cycles; must be >= 4.
- tolerance  in  CW  allowed absolute deviation |period - expected_div|.
- period  out  CW  last measured period.
- high_time  out  CW  last measured high time.
- period_valid  out  1  one-cycle pulse when period and high_time update.
- locked  out  1  ratio lock status.
- mismatch  out  1  one-cycle pulse when an out-of-tolerance period is measured.
- timeout  out  1  one-cycle pulse when no rising edge arrives within 2^CW-1 cycles.
- err_count  out  EW  saturating count of mismatch and timeout events.

Behaviour:
- Reset: one clock, clk; reset is asynchronous and active-low (clear_n). While clear_n=0, all flops and outputs are 0 and state is IDLE.
- Input capture: div_clk_in passes through a 2-flop synchronizer, then a third flop for edge detection. rise = s2 & ~s3; fall = ~s2 & s3. A rising edge on the pin produces rise 3 clk cycles later (±1 for metastability).
- Counters:
  - cnt loads 1 on rise, otherwise increments and saturates at 2^CW-1.
  - hcnt loads 1 on rise, increments while s2=1, and is frozen into a holding register h_hold on fall.
- States:
  - IDLE: counters held at 0. Leave for SYNC when enable=1.
  - SYNC: wait for the first rise (discard the partial period), then go to MEASURE. cnt does not run before that first rise.
  - MEASURE: on each rise:
    - period <= cnt; high_time <= h_hold; period_valid=1 in the following cycle.
    - Compare: in-tolerance if |cnt - expected_div| <= tolerance, computed at CW+1 bits with no wrap.
    - In tolerance: increment match_run (saturate at LOCK_CNT). Go to LOCKED when match_run reaches LOCK_CNT.
    - Out of tolerance: mismatch pulse, match_run <= 0, stay in MEASURE.
  - LOCKED: locked=1. On rise:
    - Update period/high_time/period_valid as in MEASURE.
    - Out of tolerance: mismatch pulse, locked drops in the same cycle as the pulse, match_run <= 0, go to MEASURE.
- Timeout: if cnt reaches 2^CW-1 with no rise in MEASURE or LOCKED:
  - timeout pulse, locked <= 0, match_run <= 0, go to SYNC.
  - period and period_valid are not updated.
  - In SYNC no timeout is raised.
- Simultaneous rise and saturation: the rise wins. Measure period = 2^CW-1 normally; no timeout.
- err_count increments by 1 per mismatch or timeout pulse and saturates at 2^EW-1. It is cleared only by clear_n, not by enable.
- enable=0 in any state:
  - Next cycle: state IDLE, locked=0, match_run=0.
  - period, high_time and err_count hold their values.
  - No pulses are produced.
- expected_div < 4 is unsupported; behaviour is defined only as "no hang". Input periods of 4 or more clk cycles with high and low phases of at least 2 cycles are guaranteed to be measured exactly ±1.

Decomposition:
- Shared package div_mon_pkg:
  - state enum (IDLE, SYNC, MEASURE, LOCKED)
  - default CW/EW/LOCK_CNT constants
  - CNT_MAX localparam expression
- One sub-module, sync_edge_detect: 2-flop synchronizer plus edge register with rise/fall outputs and async active-low clear. It is reusable for other clock-domain inputs in the divider project.
- FSM, counters and compare stay in div_clk_monitor.

Test Plan:
- Divide-by-8, 50% duty (div_clk_in toggles every 4 clk), expected_div=8, tolerance=0 -> period=8, high_time=4 on every period_valid; locked=1 after 4th valid; mismatch/timeout never pulse; err_count=0.
- Locked on /8, then switch to /10 -> first 10-cycle period gives mismatch pulse, locked=0, err_count=1; with expected_div=10 reprogrammed, locked re-asserts after 4 periods.
- Tolerance=1, alternate periods 7/9 around expected 8 -> no mismatch; locked after 4 valids. Period of 6 -> mismatch, locked drops.
- Stop div_clk_in while LOCKED (CW=8) -> timeout pulse 255 cycles after the last counted rise, locked=0, state SYNC; restart clock -> first rise gives no period_valid, second rise gives a valid.
- Assert clear_n=0 mid-period while LOCKED -> all outputs 0 immediately (async); after release with enable=1, resumes through SYNC.
- Drive enable=0 for 20 cycles while LOCKED -> locked=0 next cycle, period holds its value, no pulses; re-enable -> relock after 1+4 rises.
